// File: rtl/rotor_stage_ctrl.sv
// One rotor stage of a pipelined rotor cipher: stepping, ring-offset substitution via an
// external lookup, and a one-deep output register. Optional feature macro: RING_SETTING_EN.
module rotor_stage_ctrl #(
   parameter int unsigned NOTCH       = 16,
   parameter int unsigned STEP_ALWAYS = 0
) (
   input  logic       clk,
   input  logic       rst,
`ifdef RING_SETTING_EN
   input  logic [4:0] ring_set,
`endif
   input  logic       load_en,
   input  logic [4:0] load_pos,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [4:0] in_letter,
   input  logic       step_in,
   output logic [4:0] rotor_right,
   input  logic [4:0] rotor_left,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [4:0] out_letter,
   output logic       step_out,
   output logic [4:0] pos
);

   localparam logic [4:0] NOTCH_POS = 5'(NOTCH);
   localparam logic       FAST      = (STEP_ALWAYS != 0);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t     state_q, state_d;
   logic [4:0] ring;
   logic       accept;
   logic       letter_ok;
   logic       step;
   logic [4:0] p_next;
   logic [4:0] load_red;
   logic [5:0] fwd_s1, fwd_r1, fwd_s2, fwd_r2;
   logic [5:0] rev_s1, rev_r1, rev_s2, rev_r2;
   logic [4:0] sub_letter;

   function automatic logic [5:0] mod26_once(input logic [5:0] v);
      return (v >= 6'd26) ? v - 6'd26 : v;
   endfunction

   assign out_valid = (state_q == FULL);
   assign in_ready  = (!out_valid || out_ready) && !load_en && !rst;
   assign accept    = in_valid && in_ready;
   assign letter_ok = (in_letter <= 5'd25);
   assign step      = accept && (step_in || FAST) && letter_ok;
   assign load_red  = (load_pos > 5'd25) ? load_pos - 5'd26 : load_pos;

   always_comb begin
      p_next = pos;
      if (step)
         p_next = (pos == 5'd25) ? 5'd0 : pos + 5'd1;
   end

   // Forward path uses the post-step position so stepping precedes substitution.
   always_comb begin
      fwd_s1 = {1'b0, in_letter} + {1'b0, p_next};
      fwd_r1 = mod26_once(fwd_s1);
      fwd_s2 = fwd_r1 + 6'd26 - {1'b0, ring};
      fwd_r2 = mod26_once(fwd_s2);
      rotor_right = letter_ok ? fwd_r2[4:0] : 5'd31;
   end

   always_comb begin
      rev_s1 = {1'b0, rotor_left} + {1'b0, ring};
      rev_r1 = mod26_once(rev_s1);
      rev_s2 = rev_r1 + 6'd26 - {1'b0, p_next};
      rev_r2 = mod26_once(rev_s2);
      sub_letter = letter_ok ? rev_r2[4:0] : 5'd31;
   end

`ifdef RING_SETTING_EN
   always_ff @(posedge clk) begin
      if (rst)
         ring <= '0;
      else if (load_en)
         ring <= (ring_set > 5'd25) ? ring_set - 5'd26 : ring_set;
   end
`else
   assign ring = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         pos <= '0;
      else if (load_en)
         pos <= load_red;
      else if (accept)
         pos <= p_next;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= EMPTY;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL: begin
            if (accept)
               state_d = FULL;
            else if (out_ready)
               state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_letter <= '0;
         step_out   <= 1'b0;
      end else if (accept) begin
         out_letter <= sub_letter;
         step_out   <= step && (pos == NOTCH_POS);
      end
   end

endmodule

// File: tb/tb_rotor_stage_ctrl.sv
// Directed, table-driven bench for rotor_stage_ctrl with identity lookups.
module tb_rotor_stage_ctrl;

   logic       clk = 1'b0;
   logic       rst, load_en, in_valid, step_in, out_ready;
   logic [4:0] load_pos, in_letter;
`ifdef RING_SETTING_EN
   logic [4:0] ring_set;
`endif
   logic       in_ready, out_valid, step_out;
   logic [4:0] rotor_right, rotor_left, out_letter, pos;
   logic       in_ready2, out_valid2, step_out2;
   logic [4:0] rotor_right2, rotor_left2, out_letter2, pos2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign rotor_left  = rotor_right;
   assign rotor_left2 = rotor_right2;

   rotor_stage_ctrl #(.NOTCH(16), .STEP_ALWAYS(0)) dut (
      .clk(clk), .rst(rst),
`ifdef RING_SETTING_EN
      .ring_set(ring_set),
`endif
      .load_en(load_en), .load_pos(load_pos),
      .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter), .step_in(step_in),
      .rotor_right(rotor_right), .rotor_left(rotor_left),
      .out_valid(out_valid), .out_ready(out_ready), .out_letter(out_letter),
      .step_out(step_out), .pos(pos));

   rotor_stage_ctrl #(.NOTCH(16), .STEP_ALWAYS(1)) dut_fast (
      .clk(clk), .rst(rst),
`ifdef RING_SETTING_EN
      .ring_set(ring_set),
`endif
      .load_en(load_en), .load_pos(load_pos),
      .in_valid(in_valid), .in_ready(in_ready2), .in_letter(in_letter), .step_in(step_in),
      .rotor_right(rotor_right2), .rotor_left(rotor_left2),
      .out_valid(out_valid2), .out_ready(out_ready), .out_letter(out_letter2),
      .step_out(step_out2), .pos(pos2));

   typedef struct {
      logic       do_load;
      logic [4:0] lpos;
      logic       step;
      logic [4:0] letter;
      logic [4:0] e_right;
      logic [4:0] e_out;
      logic       e_so;
      logic [4:0] e_pos;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vt[0] = '{1'b1, 5'd25, 1'b1, 5'd3,  5'd3,  5'd3,  1'b0, 5'd0};
      vt[1] = '{1'b1, 5'd16, 1'b1, 5'd5,  5'd22, 5'd5,  1'b1, 5'd17};
      vt[2] = '{1'b1, 5'd16, 1'b0, 5'd5,  5'd21, 5'd5,  1'b0, 5'd16};
      vt[3] = '{1'b0, 5'd0,  1'b1, 5'd25, 5'd16, 5'd25, 1'b1, 5'd17};
      vt[4] = '{1'b0, 5'd0,  1'b1, 5'd10, 5'd2,  5'd10, 1'b0, 5'd18};
      vt[5] = '{1'b1, 5'd30, 1'b0, 5'd0,  5'd4,  5'd0,  1'b0, 5'd4};
      vt[6] = '{1'b0, 5'd0,  1'b1, 5'd27, 5'd31, 5'd31, 1'b0, 5'd4};
      vt[7] = '{1'b1, 5'd15, 1'b1, 5'd0,  5'd16, 5'd0,  1'b0, 5'd16};

      rst = 1'b1; load_en = 1'b0; load_pos = '0; in_valid = 1'b1; in_letter = 5'd1;
      step_in = 1'b1; out_ready = 1'b1;
`ifdef RING_SETTING_EN
      ring_set = '0;
`endif
      #1;
      chk("in_ready_in_reset", int'(in_ready), 0);
      tick(); tick();
      chk("rst_pos", int'(pos), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_letter", int'(out_letter), 0);
      chk("rst_step_out", int'(step_out), 0);

      // fast rotor steps on letter 0 without step_in
      rst = 1'b0; in_valid = 1'b1; in_letter = 5'd0; step_in = 1'b0;
      #1;
      chk("fast_rotor_right", int'(rotor_right2), 1);
      chk("slow_rotor_right", int'(rotor_right), 0);
      tick();
      chk("fast_out_letter", int'(out_letter2), 0);
      chk("fast_pos", int'(pos2), 1);
      chk("slow_pos", int'(pos), 0);
      in_valid = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         if (vt[i].do_load) begin
            load_en = 1'b1; load_pos = vt[i].lpos;
            tick();
            load_en = 1'b0;
         end
         in_valid = 1'b1; in_letter = vt[i].letter; step_in = vt[i].step;
         #1;
         chk($sformatf("v%0d_in_ready", i), int'(in_ready), 1);
         chk($sformatf("v%0d_rotor_right", i), int'(rotor_right), int'(vt[i].e_right));
         tick();
         in_valid = 1'b0;
         chk($sformatf("v%0d_out_valid", i), int'(out_valid), 1);
         chk($sformatf("v%0d_out_letter", i), int'(out_letter), int'(vt[i].e_out));
         chk($sformatf("v%0d_step_out", i), int'(step_out), int'(vt[i].e_so));
         chk($sformatf("v%0d_pos", i), int'(pos), int'(vt[i].e_pos));
         tick();
         chk($sformatf("v%0d_drained", i), int'(out_valid), 0);
      end

      // load_en blocks accept and leaves the output register alone
      load_en = 1'b1; load_pos = 5'd3; in_valid = 1'b1; in_letter = 5'd5; step_in = 1'b1;
      #1;
      chk("load_blocks_ready", int'(in_ready), 0);
      tick();
      load_en = 1'b0; in_valid = 1'b0;
      chk("load_pos_set", int'(pos), 3);
      chk("load_no_output", int'(out_valid), 0);

      // stall for three cycles, then drain and accept in the same cycle
      load_en = 1'b1; load_pos = 5'd0;
      tick();
      load_en = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1; in_letter = 5'd7; step_in = 1'b0;
      tick();
      chk("stall_first_letter", int'(out_letter), 7);
      in_letter = 5'd9;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("stall%0d_in_ready", c), int'(in_ready), 0);
         tick();
         chk($sformatf("stall%0d_out_letter", c), int'(out_letter), 7);
         chk($sformatf("stall%0d_out_valid", c), int'(out_valid), 1);
      end
      out_ready = 1'b1;
      #1;
      chk("drain_in_ready", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("no_bubble_valid", int'(out_valid), 1);
      chk("no_bubble_letter", int'(out_letter), 9);
      tick();
      chk("after_drain_valid", int'(out_valid), 0);

      // reset in the middle of a stall drops the held letter
      load_en = 1'b1; load_pos = 5'd12;
      tick();
      load_en = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1; in_letter = 5'd27; step_in = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("illegal_out_letter", int'(out_letter), 31);
      chk("illegal_pos", int'(pos), 12);
      tick();
      rst = 1'b1; in_valid = 1'b1; in_letter = 5'd2;
      #1;
      chk("rst_stall_in_ready", int'(in_ready), 0);
      tick();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("rst_stall_out_valid", int'(out_valid), 0);
      chk("rst_stall_pos", int'(pos), 0);
      chk("rst_stall_step_out", int'(step_out), 0);

`ifdef RING_SETTING_EN
      load_en = 1'b1; load_pos = 5'd0; ring_set = 5'd1;
      tick();
      load_en = 1'b0;
      in_valid = 1'b1; in_letter = 5'd0; step_in = 1'b0;
      #1;
      chk("ring_rotor_right", int'(rotor_right), 25);
      tick();
      in_valid = 1'b0;
      chk("ring_out_letter", int'(out_letter), 0);
      chk("ring_pos", int'(pos), 0);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
